// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host controller with receive FIFO, host-to-device transmit and sticky error flags.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 32768,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int RX_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ps2_clk_i,
  input  logic                        ps2_dat_i,
  output logic                        ps2_clk_o,
  output logic                        ps2_dat_o,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ack,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        err_parity,
  output logic                        err_frame,
  output logic                        err_overflow,
  output logic                        err_timeout,
  output logic                        tx_nak,
  input  logic                        err_clear
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_REQ, TX_SHIFT, TX_ACK, TX_DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic clk_prev_q, clk_s, dat_s, clkneg;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d;
  logic par_q, par_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] mem_q [RX_DEPTH];
  logic err_parity_q, err_parity_d, err_frame_q, err_frame_d, err_overflow_q, err_overflow_d;
  logic err_timeout_q, err_timeout_d, tx_nak_q, tx_nak_d;
  logic push, do_push, pop, full, pe, fe, te, nak, wd_state;
  logic [9:0] tx_frame;
  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign clkneg = clk_prev_q & ~clk_s;
  assign tx_frame = {~^sr_q, sr_q, 1'b0};
  assign wd_state = state_q == RX || state_q == TX_SHIFT || state_q == TX_ACK || state_q == TX_DONE;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    sr_d = sr_q;
    par_d = par_q;
    push = 1'b0;
    pe = 1'b0;
    fe = 1'b0;
    te = 1'b0;
    nak = 1'b0;
    case (state_q)
      IDLE:
        if (clkneg && !dat_s) begin
          state_d = RX;
          bit_d = '0;
        end else if (tx_valid && !clkneg) begin
          state_d = TX_INHIBIT;
          sr_d = tx_data;
        end
      RX:
        if (clkneg) begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) sr_d = {dat_s, sr_q[7:1]};
          else if (bit_q == 4'd8) par_d = dat_s;
          else begin
            state_d = IDLE;
            fe = !dat_s;
            pe = dat_s && !(^{sr_q, par_q});
            push = dat_s && (^{sr_q, par_q});
          end
        end
      TX_INHIBIT: state_d = cnt_q == CW'(INHIBIT_CYCLES - 1) ? TX_REQ : TX_INHIBIT;
      TX_REQ: begin
        state_d = TX_SHIFT;
        bit_d = '0;
      end
      TX_SHIFT:
        if (clkneg) begin
          bit_d = bit_q + 4'd1;
          state_d = bit_q == 4'd9 ? TX_ACK : TX_SHIFT;
        end
      TX_ACK:
        if (clkneg) begin
          nak = dat_s;
          state_d = TX_DONE;
        end
      TX_DONE: state_d = clk_s && dat_s ? IDLE : TX_DONE;
      default: state_d = IDLE;
    endcase
    // a stalled frame is abandoned without pushing anything
    if (wd_state && !clkneg && state_d == state_q && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      state_d = IDLE;
      te = 1'b1;
    end
    // the inhibit count must not be restarted by the falling edge we cause ourselves
    cnt_d = (state_q == IDLE || state_d != state_q || (clkneg && state_q != TX_INHIBIT)) ? '0 : cnt_q + 1'b1;
    pop = rx_ack && count_q != '0;
    full = count_q == (AW+1)'(RX_DEPTH);
    do_push = push && (!full || pop);
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(pop);
    err_parity_d = (err_parity_q & ~err_clear) | pe;
    err_frame_d = (err_frame_q & ~err_clear) | fe;
    err_overflow_d = (err_overflow_q & ~err_clear) | (push && full && !pop);
    err_timeout_d = (err_timeout_q & ~err_clear) | te;
    tx_nak_d = (tx_nak_q & ~err_clear) | nak;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      cnt_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      par_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      err_parity_q <= 1'b0;
      err_frame_q <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q <= 1'b0;
      tx_nak_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      clk_prev_q <= clk_s;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      par_q <= par_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      err_parity_q <= err_parity_d;
      err_frame_q <= err_frame_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q <= err_timeout_d;
      tx_nak_q <= tx_nak_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_q] <= sr_q;
  end
  always_comb begin
    ps2_clk_o = reset || !(state_q == TX_INHIBIT || state_q == TX_REQ);
    ps2_dat_o = reset ? 1'b1 : state_q == TX_REQ ? 1'b0 : state_q == TX_SHIFT ? tx_frame[bit_q] : 1'b1;
    tx_ready = !reset && state_q == IDLE;
    rx_valid = count_q != '0;
    rx_data = mem_q[rd_q];
    rx_count = count_q;
    err_parity = err_parity_q;
    err_frame = err_frame_q;
    err_overflow = err_overflow_q;
    err_timeout = err_timeout_q;
    tx_nak = tx_nak_q;
  end
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: drives a modelled PS/2 device against the host controller, scoreboarding received bytes and transmitted bits.
module tb_ps2_host_ctrl;
  localparam int INH = 20;
  localparam int TO = 200;
  localparam int DEPTH = 4;
  localparam int H = 5;
  logic clk = 1'b0, reset = 1'b1;
  logic dev_clk = 1'b1, dev_dat = 1'b1;
  logic ps2_clk_i, ps2_dat_i, ps2_clk_o, ps2_dat_o;
  logic [7:0] tx_data = '0, rx_data;
  logic tx_valid = 1'b0, tx_ready, rx_valid, rx_ack = 1'b0, err_clear = 1'b0;
  logic [$clog2(DEPTH):0] rx_count;
  logic err_parity, err_frame, err_overflow, err_timeout, tx_nak;
  int checks = 0, failures = 0;
  logic [7:0] exp_rx [$];
  logic exp_bits [$];
  assign ps2_clk_i = dev_clk & ps2_clk_o;
  assign ps2_dat_i = dev_dat & ps2_dat_o;
  ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .RX_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_clk_i(ps2_clk_i), .ps2_dat_i(ps2_dat_i),
    .ps2_clk_o(ps2_clk_o), .ps2_dat_o(ps2_dat_o), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .rx_count(rx_count), .err_parity(err_parity), .err_frame(err_frame),
    .err_overflow(err_overflow), .err_timeout(err_timeout), .tx_nak(tx_nak), .err_clear(err_clear)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_errs();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask
  // device-to-host frame; optionally pops the FIFO in the very cycle the stop bit pushes
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits, input logic pop_at_stop);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = f[i];
      tick(H);
      dev_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        tick(2);
        chk("pop_at_push_head", rx_data, exp_rx.pop_front());
        rx_ack = 1'b1;
        tick(1);
        rx_ack = 1'b0;
        tick(H - 3);
      end else tick(H);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    tick(H);
  endtask
  task automatic pop_check(input string tag);
    chk({tag, "_valid"}, rx_valid, 1);
    if (rx_valid && exp_rx.size() > 0) chk(tag, rx_data, exp_rx.pop_front());
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask
  task automatic host_send(input logic [7:0] b, input logic ack);
    int n;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(~^b);
    exp_bits.push_back(1'b1);
    chk("tx_ready_pre", tx_ready, 1);
    tx_data = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_o == 1'b0 && ps2_dat_o == 1'b1 && n < 1000) begin
      n++;
      tick(1);
    end
    chk("inhibit_len", n, INH);
    chk("req_clk", ps2_clk_o, 0);
    chk("req_dat", ps2_dat_o, 0);
    tick(1);
    chk("shift_clk_released", ps2_clk_o, 1);
    tick(H);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("tx_bit%0d", i), ps2_dat_i, exp_bits.pop_front());
      if (i < 10) begin
        dev_clk = 1'b0;
        tick(H);
        dev_clk = 1'b1;
        tick(H);
      end
    end
    dev_dat = ack;
    tick(1);
    dev_clk = 1'b0;
    tick(H);
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    tick(H);
    chk("tx_nak", tx_nak, ack);
    chk("tx_ready_post", tx_ready, 1);
  endtask
  initial begin
    #5000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int n;
    tick(3);
    chk("rst_count", rx_count, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_clk_o", ps2_clk_o, 1);
    chk("rst_dat_o", ps2_dat_o, 1);
    chk("rst_flags", {err_parity, err_frame, err_overflow, err_timeout, tx_nak}, 0);
    reset = 1'b0;
    tick(1);
    chk("post_rst_tx_ready", tx_ready, 1);
    exp_rx.push_back(8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0);
    chk("rx1_count", rx_count, 1);
    pop_check("rx1_data");
    chk("rx1_count_after_ack", rx_count, 0);
    host_send(8'hED, 1'b0);
    host_send(8'h5A, 1'b1);
    clear_errs();
    chk("nak_cleared", tx_nak, 0);
    send_frame(8'h3C, 1'b1, 1'b1, 11, 1'b0);
    chk("parity_err", err_parity, 1);
    chk("parity_count", rx_count, 0);
    clear_errs();
    chk("parity_cleared", err_parity, 0);
    send_frame(8'h77, 1'b1, 1'b0, 11, 1'b0);
    chk("frame_err", err_frame, 1);
    chk("frame_over_parity", err_parity, 0);
    chk("frame_count", rx_count, 0);
    clear_errs();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) exp_rx.push_back(8'(8'h11 * (i + 1)));
      send_frame(8'(8'h11 * (i + 1)), 1'b0, 1'b1, 11, 1'b0);
    end
    chk("ovf_count", rx_count, DEPTH);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_head", rx_data, exp_rx[0]);
    clear_errs();
    exp_rx.push_back(8'h66);
    send_frame(8'h66, 1'b0, 1'b1, 11, 1'b1);
    chk("full_pushpop_count", rx_count, DEPTH);
    chk("full_pushpop_no_ovf", err_overflow, 0);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i));
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
    chk("empty_ack_count", rx_count, 0);
    chk("empty_ack_valid", rx_valid, 0);
    send_frame(8'hA5, 1'b0, 1'b1, 5, 1'b0);
    tick(TO - 50);
    chk("timeout_early", err_timeout, 0);
    tick(100);
    chk("timeout_flag", err_timeout, 1);
    chk("timeout_count", rx_count, 0);
    chk("timeout_idle", tx_ready, 1);
    clear_errs();
    chk("timeout_cleared", err_timeout, 0);
    tx_data = 8'hED;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_o == 1'b0 && n < 1000) begin
      n++;
      tick(1);
    end
    tick(H);
    for (int i = 0; i < 2; i++) begin
      dev_clk = 1'b0;
      tick(H);
      dev_clk = 1'b1;
      tick(H);
    end
    chk("midtx_dat_driven", ps2_dat_o, 0);
    reset = 1'b1;
    tick(1);
    chk("midtx_rst_clk_o", ps2_clk_o, 1);
    chk("midtx_rst_dat_o", ps2_dat_o, 1);
    chk("midtx_rst_flags", {err_parity, err_frame, err_overflow, err_timeout, tx_nak}, 0);
    reset = 1'b0;
    tick(1);
    chk("midtx_tx_ready", tx_ready, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
